// File: rtl/turn_shot_controller_if.sv
// Turn/shot handshake bundle between the game FSM, key synchronizers,
// bullet datapath (master side) and the turn_shot_controller (slave side).
interface turn_shot_controller_if;
  logic       game_start;
  logic       player1flag;
  logic       player2flag;
  logic       key_up;
  logic       key_down;
  logic       key_left;
  logic       key_right;
  logic       key_fire;
  logic       bull_stop;
  logic       bull_hit;
  logic       bull_shoot_flag1;
  logic       bull_shoot_flag2;
  logic       bull_stop_flag1;
  logic       bull_stop_flag2;
  logic [6:0] shot_angle;
  logic [3:0] shot_power;
  logic [3:0] health_1;
  logic [3:0] health_2;
  logic [9:0] turn_timer;
  logic [1:0] active_player;

  modport master (
    output game_start, player1flag, player2flag,
           key_up, key_down, key_left, key_right, key_fire,
           bull_stop, bull_hit,
    input  bull_shoot_flag1, bull_shoot_flag2, bull_stop_flag1, bull_stop_flag2,
           shot_angle, shot_power, health_1, health_2, turn_timer, active_player
  );

  modport slave (
    input  game_start, player1flag, player2flag,
           key_up, key_down, key_left, key_right, key_fire,
           bull_stop, bull_hit,
    output bull_shoot_flag1, bull_shoot_flag2, bull_stop_flag1, bull_stop_flag2,
           shot_angle, shot_power, health_1, health_2, turn_timer, active_player
  );
endinterface

// File: rtl/turn_shot_controller.sv
// Sequences one player's shot per turn: aim with countdown, fire, wait for
// landing (or timeout), apply damage, then hand the turn back to the game FSM.
module turn_shot_controller #(
  parameter int unsigned TURN_FRAMES    = 600,
  parameter int unsigned FLIGHT_TIMEOUT = 255,
  parameter int unsigned MAX_HEALTH     = 10,
  parameter int unsigned DAMAGE         = 3,
  parameter int unsigned ANGLE_MAX      = 90,
  parameter int unsigned POWER_MAX      = 15
) (
  input logic                   frame_clk,
  input logic                   Reset,
  turn_shot_controller_if.slave bus
);

  localparam logic [9:0] TIMER_LOAD  = 10'(TURN_FRAMES);
  localparam logic [7:0] FLIGHT_LOAD = 8'(FLIGHT_TIMEOUT);
  localparam logic [3:0] HEALTH_LOAD = 4'(MAX_HEALTH);
  localparam logic [3:0] DMG         = 4'(DAMAGE);
  localparam logic [6:0] ANG_MAX     = 7'(ANGLE_MAX);
  localparam logic [3:0] PWR_MAX     = 4'(POWER_MAX);
  localparam logic [6:0] ANG_INIT    = 7'd45;
  localparam logic [3:0] PWR_INIT    = 4'd8;

  typedef enum logic [2:0] {IDLE, AIM, FIRE, FLIGHT, SCORE, DONE} state_t;

  state_t     state;
  logic       owner_p2;
  logic [6:0] angle_1, angle_2, cur_angle, next_angle;
  logic [3:0] power_1, power_2, cur_power, next_power;
  logic [3:0] health_1_q, health_2_q;
  logic [9:0] timer;
  logic [7:0] flight_cnt;
  logic       hit_q;
  logic       fire_prev;
  logic       fire_edge;

  function automatic logic [3:0] apply_damage(input logic [3:0] h);
    return (h <= DMG) ? 4'd0 : h - DMG;
  endfunction

  assign cur_angle = owner_p2 ? angle_2 : angle_1;
  assign cur_power = owner_p2 ? power_2 : power_1;
  assign fire_edge = bus.key_fire & ~fire_prev;

  // Opposing keys pressed together cancel; both ends saturate.
  always_comb begin
    next_angle = cur_angle;
    next_power = cur_power;
    if (bus.key_up && !bus.key_down && cur_angle < ANG_MAX)
      next_angle = cur_angle + 7'd1;
    else if (bus.key_down && !bus.key_up && cur_angle != 7'd0)
      next_angle = cur_angle - 7'd1;
    if (bus.key_right && !bus.key_left && cur_power < PWR_MAX)
      next_power = cur_power + 4'd1;
    else if (bus.key_left && !bus.key_right && cur_power > 4'd1)
      next_power = cur_power - 4'd1;
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      owner_p2   <= 1'b0;
      angle_1    <= ANG_INIT;
      angle_2    <= ANG_INIT;
      power_1    <= PWR_INIT;
      power_2    <= PWR_INIT;
      health_1_q <= HEALTH_LOAD;
      health_2_q <= HEALTH_LOAD;
      timer      <= '0;
      flight_cnt <= '0;
      hit_q      <= 1'b0;
      fire_prev  <= 1'b0;
    end else begin
      fire_prev <= bus.key_fire;
      case (state)
        IDLE: begin
          if (bus.game_start) begin
            angle_1    <= ANG_INIT;
            angle_2    <= ANG_INIT;
            power_1    <= PWR_INIT;
            power_2    <= PWR_INIT;
            health_1_q <= HEALTH_LOAD;
            health_2_q <= HEALTH_LOAD;
          end else if (bus.player1flag || bus.player2flag) begin
            owner_p2 <= ~bus.player1flag;
            timer    <= TIMER_LOAD;
            state    <= AIM;
          end
        end
        AIM: begin
          if (owner_p2) begin
            angle_2 <= next_angle;
            power_2 <= next_power;
          end else begin
            angle_1 <= next_angle;
            power_1 <= next_power;
          end
          timer <= timer - 10'd1;
          // Fire edge and expiry in the same frame still yield a single FIRE.
          if (fire_edge || timer <= 10'd1) begin
            timer <= '0;
            state <= FIRE;
          end
        end
        FIRE: begin
          flight_cnt <= FLIGHT_LOAD;
          state      <= FLIGHT;
        end
        FLIGHT: begin
          if (bus.bull_stop) begin
            hit_q <= bus.bull_hit;
            state <= SCORE;
          end else begin
            flight_cnt <= flight_cnt - 8'd1;
            if (flight_cnt <= 8'd1) begin
              hit_q <= 1'b0;
              state <= SCORE;
            end
          end
        end
        SCORE: begin
          if (hit_q) begin
            if (owner_p2) health_1_q <= apply_damage(health_1_q);
            else          health_2_q <= apply_damage(health_2_q);
          end
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bull_shoot_flag1 = (state == FIRE) && !owner_p2;
  assign bus.bull_shoot_flag2 = (state == FIRE) &&  owner_p2;
  assign bus.bull_stop_flag1  = (state == DONE) && !owner_p2;
  assign bus.bull_stop_flag2  = (state == DONE) &&  owner_p2;
  assign bus.shot_angle       = cur_angle;
  assign bus.shot_power       = cur_power;
  assign bus.health_1         = health_1_q;
  assign bus.health_2         = health_2_q;
  assign bus.turn_timer       = timer;
  assign bus.active_player    = (state == IDLE) ? 2'b00 : (owner_p2 ? 2'b10 : 2'b01);

endmodule

// File: tb/tb_turn_shot_controller.sv
// Scoreboard bench: stimulus queues the expected shoot/stop pulses, a monitor
// pops and compares them whenever the controller raises a flag.
module tb_turn_shot_controller;

  logic frame_clk = 1'b0;
  logic Reset     = 1'b0;
  always #5 frame_clk = ~frame_clk;

  turn_shot_controller_if bus();

  turn_shot_controller #(
    .TURN_FRAMES   (600),
    .FLIGHT_TIMEOUT(255),
    .MAX_HEALTH    (10),
    .DAMAGE        (3),
    .ANGLE_MAX     (90),
    .POWER_MAX     (15)
  ) dut (
    .frame_clk(frame_clk),
    .Reset    (Reset),
    .bus      (bus)
  );

  typedef struct packed {
    logic [3:0] flags;   // {shoot1, shoot2, stop1, stop2}
    logic [6:0] angle;
    logic [3:0] power;
    logic [3:0] h1;
    logic [3:0] h2;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // bench-side model of the aim and health registers
  logic [6:0] m_ang[2];
  logic [3:0] m_pwr[2];
  logic [3:0] m_h1, m_h2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge frame_clk);
    #1;
  endtask

  task automatic model_reset();
    m_ang[0] = 7'd45; m_ang[1] = 7'd45;
    m_pwr[0] = 4'd8;  m_pwr[1] = 4'd8;
    m_h1 = 4'd10; m_h2 = 4'd10;
  endtask

  task automatic push_shoot(input int p);
    exp_t e;
    e.flags = (p == 1) ? 4'b1000 : 4'b0100;
    e.angle = m_ang[p-1];
    e.power = m_pwr[p-1];
    e.h1 = m_h1; e.h2 = m_h2;
    exp_q.push_back(e);
  endtask

  task automatic push_stop(input int p, input bit hit);
    exp_t e;
    if (hit) begin
      if (p == 1) m_h2 = (m_h2 <= 4'd3) ? 4'd0 : m_h2 - 4'd3;
      else        m_h1 = (m_h1 <= 4'd3) ? 4'd0 : m_h1 - 4'd3;
    end
    e.flags = (p == 1) ? 4'b0010 : 4'b0001;
    e.angle = m_ang[p-1];
    e.power = m_pwr[p-1];
    e.h1 = m_h1; e.h2 = m_h2;
    exp_q.push_back(e);
  endtask

  // Monitor: any flag must match the head of the queue; a flag held longer
  // than one frame finds the queue empty or mismatched.
  always @(negedge frame_clk) begin
    logic [3:0] f;
    exp_t e;
    f = {bus.bull_shoot_flag1, bus.bull_shoot_flag2, bus.bull_stop_flag1, bus.bull_stop_flag2};
    if (Reset && f != 4'b0000) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: flags=%b with nothing queued", f);
      end else begin
        e = exp_q.pop_front();
        if (f !== e.flags || bus.shot_angle !== e.angle || bus.shot_power !== e.power ||
            (f[1:0] != 2'b00 && (bus.health_1 !== e.h1 || bus.health_2 !== e.h2))) begin
          n_fail++;
          $display("FAIL pulse_scoreboard: got flags=%b ang=%0d pwr=%0d h1=%0d h2=%0d, expected flags=%b ang=%0d pwr=%0d h1=%0d h2=%0d",
                   f, bus.shot_angle, bus.shot_power, bus.health_1, bus.health_2,
                   e.flags, e.angle, e.power, e.h1, e.h2);
        end
      end
    end
  end

  task automatic clear_inputs();
    bus.game_start = 0; bus.player1flag = 0; bus.player2flag = 0;
    bus.key_up = 0; bus.key_down = 0; bus.key_left = 0; bus.key_right = 0;
    bus.key_fire = 0; bus.bull_stop = 0; bus.bull_hit = 0;
  endtask

  // Full turn: immediate fire, bullet lands one frame into FLIGHT.
  task automatic quick_turn(input int p, input bit hit, input bit gs);
    if (p == 1) bus.player1flag = 1; else bus.player2flag = 1;
    step(1);
    bus.player1flag = 0; bus.player2flag = 0;
    check("qt_active", bus.active_player, (p == 1) ? 2'b01 : 2'b10);
    bus.game_start = gs;
    bus.key_fire = 1;
    push_shoot(p);
    step(1);                       // FIRE
    bus.key_fire = 0;
    step(1);                       // FLIGHT
    bus.bull_stop = 1; bus.bull_hit = hit;
    push_stop(p, hit);
    step(1);                       // SCORE
    bus.bull_stop = 0; bus.bull_hit = 0; bus.game_start = 0;
    step(2);                       // DONE, IDLE
    check("qt_idle", bus.active_player, 2'b00);
  endtask

  initial begin
    int n;
    clear_inputs();
    model_reset();
    step(2);
    check("rst_h1", bus.health_1, 10);
    check("rst_h2", bus.health_2, 10);
    check("rst_angle", bus.shot_angle, 45);
    check("rst_power", bus.shot_power, 8);
    check("rst_timer", bus.turn_timer, 0);
    check("rst_active", bus.active_player, 2'b00);
    Reset = 1;
    step(1);

    // Turn 1: P1 saturates angle high and power low, stray bull_stop in FIRE
    bus.player1flag = 1;
    step(1);
    bus.player1flag = 0;
    check("t1_active", bus.active_player, 2'b01);
    check("t1_timer_load", bus.turn_timer, 600);
    bus.key_up = 1; step(50); bus.key_up = 0;
    check("t1_angle_sat", bus.shot_angle, 90);
    bus.key_left = 1; step(20); bus.key_left = 0;
    check("t1_power_sat", bus.shot_power, 1);
    check("t1_timer", bus.turn_timer, 530);
    m_ang[0] = 7'd90; m_pwr[0] = 4'd1;
    bus.key_fire = 1;
    push_shoot(1);
    step(1);                       // FIRE
    bus.key_fire = 0;
    bus.bull_stop = 1; bus.bull_hit = 1;
    step(1);                       // FLIGHT, stop during FIRE ignored
    bus.bull_stop = 0; bus.bull_hit = 0;
    step(3);
    check("t1_in_flight", bus.active_player, 2'b01);
    bus.bull_stop = 1; bus.bull_hit = 1;
    push_stop(1, 1);
    step(1);                       // SCORE
    bus.bull_stop = 0; bus.bull_hit = 0;
    check("t1_h2_before", bus.health_2, 10);
    step(1);                       // DONE
    check("t1_h2_after", bus.health_2, 7);
    check("t1_stop_flag", bus.bull_stop_flag1, 1);
    step(1);
    check("t1_idle", bus.active_player, 2'b00);

    // Turn 2: fire held across boundary, opposing keys, fire at timer 590
    bus.key_fire = 1;
    bus.player1flag = 1;
    step(1);
    bus.player1flag = 0;
    step(2);
    bus.key_fire = 0;
    bus.key_up = 1; bus.key_down = 1; bus.key_left = 1; bus.key_right = 1;
    step(8);
    bus.key_up = 0; bus.key_down = 0; bus.key_left = 0; bus.key_right = 0;
    check("t2_timer_590", bus.turn_timer, 590);
    check("t2_angle_hold", bus.shot_angle, 90);
    check("t2_power_hold", bus.shot_power, 1);
    bus.key_fire = 1;
    push_shoot(1);
    step(1);
    bus.key_fire = 0;
    check("t2_shoot1", bus.bull_shoot_flag1, 1);
    check("t2_timer_zero", bus.turn_timer, 0);
    step(1);
    bus.bull_stop = 1; bus.bull_hit = 1;
    push_stop(1, 1);
    step(1);
    bus.bull_stop = 0; bus.bull_hit = 0;
    step(2);
    check("t2_h2", bus.health_2, 4);

    // Turn 3: P2 aims down/right then auto-fires at expiry
    bus.player2flag = 1;
    step(1);
    bus.player2flag = 0;
    check("t3_active", bus.active_player, 2'b10);
    bus.key_down = 1; step(50); bus.key_down = 0;
    bus.key_right = 1; step(10); bus.key_right = 0;
    check("t3_angle_floor", bus.shot_angle, 0);
    check("t3_power_ceil", bus.shot_power, 15);
    m_ang[1] = 7'd0; m_pwr[1] = 4'd15;
    step(539);
    check("t3_timer_one", bus.turn_timer, 1);
    push_shoot(2);
    step(1);
    check("t3_autofire", bus.bull_shoot_flag2, 1);
    check("t3_timer_zero", bus.turn_timer, 0);
    step(1);
    bus.bull_stop = 1; bus.bull_hit = 1;
    push_stop(2, 1);
    step(1);
    bus.bull_stop = 0; bus.bull_hit = 0;
    step(2);
    check("t3_h1", bus.health_1, 7);

    // Turn 4: both flags (P1 wins), no landing -> timeout miss
    bus.player1flag = 1; bus.player2flag = 1;
    step(1);
    bus.player1flag = 0; bus.player2flag = 0;
    check("t4_priority", bus.active_player, 2'b01);
    bus.key_fire = 1;
    push_shoot(1);
    step(1);
    bus.key_fire = 0;
    push_stop(1, 0);
    n = 0;
    while (!bus.bull_stop_flag1 && n < 400) begin
      step(1);
      n++;
    end
    check("t4_timeout_latency", n, 257);
    check("t4_h2_unchanged", bus.health_2, 4);
    step(1);

    // Health floor: 4 -> 1 -> 0 -> 0, then a P2 miss
    quick_turn(1, 1, 0);
    check("h2_one", bus.health_2, 1);
    quick_turn(1, 1, 0);
    check("h2_floor", bus.health_2, 0);
    quick_turn(1, 1, 0);
    check("h2_stay_zero", bus.health_2, 0);
    quick_turn(2, 0, 0);
    check("p2_miss_h1", bus.health_1, 7);

    // game_start reloads in IDLE, is ignored during a turn
    bus.game_start = 1;
    step(1);
    bus.game_start = 0;
    model_reset();
    check("gs_h1", bus.health_1, 10);
    check("gs_h2", bus.health_2, 10);
    quick_turn(1, 1, 0);
    quick_turn(1, 1, 1);
    check("gs_ignored", bus.health_2, 4);

    // Reset during FLIGHT
    bus.player1flag = 1;
    step(1);
    bus.player1flag = 0;
    bus.key_fire = 1;
    push_shoot(1);
    step(1);
    bus.key_fire = 0;
    step(5);
    #2 Reset = 0;
    #1;
    model_reset();
    check("mid_rst_h2", bus.health_2, 10);
    check("mid_rst_active", bus.active_player, 2'b00);
    check("mid_rst_angle", bus.shot_angle, 45);
    check("mid_rst_pulses", {bus.bull_shoot_flag1, bus.bull_shoot_flag2,
                             bus.bull_stop_flag1, bus.bull_stop_flag2}, 4'b0000);
    step(2);
    Reset = 1;
    step(3);
    check("post_rst_idle", bus.active_player, 2'b00);
    quick_turn(2, 1, 0);
    check("post_rst_h1", bus.health_1, 7);

    step(3);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/turn_shot_controller.md
Name: turn_shot_controller

Overview:
- Sequences one player's shot per turn, between the game FSM and the bullet/tank datapath.
- Triggered by player1flag/player2flag from the game FSM. Runs the aim phase (angle/power adjust plus a turn countdown), then fires the bullet and waits for it to land.
- Applies damage to the opponent's health register, then returns bull_stop_flag1/2 so the game FSM can advance.
- Owns health_1/health_2 and the per-player aim registers.

Parameters:
- TURN_FRAMES, 600, aim-phase length in frames; auto-fire at expiry.
- FLIGHT_TIMEOUT, 255, max frames to wait for bull_stop before scoring a miss.
- MAX_HEALTH, 10, health reload value (must be ≤15).
- DAMAGE, 3, health removed per hit.
- ANGLE_MAX, 90, upper angle limit in degrees.
- POWER_MAX, 15, upper power limit.

Ports:
- frame_clk  in  1  frame-rate clock; all logic on the rising edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- game_start  in  1  level; reloads health and aim registers when the block is in IDLE.
- player1flag  in  1  player 1 turn grant (level) from the game FSM.
- player2flag  in  1  player 2 turn grant (level) from the game FSM.
- key_up, key_down, key_left, key_right, key_fire  in  1 each  synchronized key levels.
- bull_stop  in  1  bullet has landed or left the screen.
- bull_hit  in  1  qualified by bull_stop; the bullet struck the opponent's tank.
- bull_shoot_flag1, bull_shoot_flag2  out  1  one-frame launch pulse for the player's bullet.
- bull_stop_flag1, bull_stop_flag2  out  1  one-frame "turn resolved" pulse to the game FSM.
- shot_angle  out  7  active player's angle (0..ANGLE_MAX).
- shot_power  out  4  active player's power (1..POWER_MAX).
- health_1, health_2  out  4  player health.
- turn_timer  out  10  frames remaining in the aim phase; 0 outside AIM.
- active_player  out  2  01 = player 1, 10 = player 2, 00 = none.

Behaviour:
- Reset (Reset=0), asynchronous:
  - state=IDLE; health_1 = health_2 = MAX_HEALTH.
  - Both angles = 45; both powers = 8.
  - All pulses 0; turn_timer=0; active_player=00.
- All outputs are registered or decoded from the state register (Moore). Flags never depend combinationally on inputs.
- States: IDLE, AIM, FIRE, FLIGHT, SCORE, DONE.
- IDLE:
  - If game_start: reload health and aim registers (reset values); stay in IDLE.
  - Else if player1flag: owner=P1, go to AIM. Else if player2flag: owner=P2, go to AIM. P1 has priority if both flags are high.
  - On entry to AIM, turn_timer := TURN_FRAMES.
  - game_start is ignored in every state other than IDLE.
- AIM, evaluated each frame on the owner's registers:
  - key_up alone: angle+1, saturating at ANGLE_MAX. key_down alone: angle−1, saturating at 0. Both pressed: no change.
  - key_right alone: power+1, saturating at POWER_MAX. key_left alone: power−1, saturating at 1. Both pressed: no change.
  - turn_timer decrements by 1 per frame.
  - A key_fire rising edge (fire_prev=0, key_fire=1) goes to FIRE. A key held across the turn boundary does not fire.
  - When turn_timer==1 and it decrements to 0, go to FIRE in the same edge (auto-fire with the current aim).
  - A fire edge and timer expiry in the same frame give a single FIRE.
  - Aim adjustments in the frame that leaves AIM still take effect.
- FIRE (exactly 1 frame):
  - bull_shoot_flagN=1 for the owner.
  - shot_angle/shot_power are stable from this frame until DONE exits.
  - Load flight_cnt := FLIGHT_TIMEOUT; go to FLIGHT.
- FLIGHT:
  - If bull_stop: hit_q := bull_hit; go to SCORE.
  - Else flight_cnt decrements; at 0, hit_q := 0 and go to SCORE (timeout counts as a miss).
  - A bull_stop in the FIRE frame is ignored.
- SCORE (1 frame): if hit_q, the opponent's health := (health ≤ DAMAGE) ? 0 : health − DAMAGE. Go to DONE.
- DONE (1 frame):
  - bull_stop_flagN=1 for the owner.
  - Health is already updated, so the game FSM sees new health on the edge it consumes the flag.
  - Go to IDLE; active_player=00.
- Re-trigger: IDLE accepts a flag only from the frame after DONE. A player flag still high in that frame starts a new turn; this is the game FSM's responsibility.
- Latency:
  - Fire edge sampled at edge N → bull_shoot_flag high during frame N+1.
  - bull_stop sampled at edge M → health updated at M+1 → bull_stop_flag high during frame M+2.
- Reset mid-operation: immediately returns to the reset values above. No pulse is emitted.

Test Plan:
- Reset=0 then 1; P1 flag high; angle up ×50 frames → shot_angle saturates at 90. Power left ×20 → shot_power=1.
- P1 turn, key_fire rises at frame 10 of AIM → bull_shoot_flag1 high for exactly 1 frame at frame 11. turn_timer reads 590 at the fire edge.
- P2 turn, no keys pressed → auto-fire after 600 frames. bull_shoot_flag2 pulses; turn_timer reaches 0.
- P1 fires, bull_stop=1 with bull_hit=1, health_2=10 → health_2=7 one frame later. bull_stop_flag1 pulses the following frame.
- health_2=2, hit → health_2=0 (no wrap to 15). A hit with health 0 stays 0.
- Fire, then bull_stop never asserted → after 255 frames, miss scored: health unchanged, bull_stop_flag pulses. Assert Reset=0 during FLIGHT → IDLE, health=10, no pulses.
